input_conditioner: RTL and testbench

//  Upstream front end of picomips. Conditions the raw board inputs (ready button, 8 switches) into clean, synchronous signals.
//  Two-flop synchronises all inputs. Debounces ready and drives the debounced level to the CPU ready input.

---
 rtl/picomips_pkg.sv | 8 +
 rtl/sync_debounce.sv | 47 ++++
 rtl/input_conditioner.sv | 63 ++++++
 tb/tb_input_conditioner.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/picomips_pkg.sv
// Shared picomips front-end constants.
package picomips_pkg;

  localparam int unsigned SW_WIDTH            = 8;
  localparam int unsigned DEFAULT_DEBOUNCE    = 16;
  localparam int unsigned DEFAULT_SYNC_STAGES = 2;

endpackage : picomips_pkg

// File: rtl/sync_debounce.sv
// Single-bit synchroniser followed by a debounce counter.
// Emits the debounced level and a combinational pulse on the edge where the level rises.
module sync_debounce
  import picomips_pkg::*;
#(
  parameter int unsigned SYNC_STAGES     = DEFAULT_SYNC_STAGES,
  parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic level,
  output logic rise_c
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [CNT_W-1:0]       cnt_q;
  logic                   din_s;
  logic                   flip;

  assign din_s  = sync_q[SYNC_STAGES-1];
  // Input has disagreed with the level for DEBOUNCE_CYCLES consecutive edges.
  assign flip   = (din_s != level) && (cnt_q == CNT_MAX);
  assign rise_c = flip && din_s;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q <= '0;
      cnt_q  <= '0;
      level  <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], din};
      if (din_s == level) begin
        cnt_q <= '0;
      end else if (flip) begin
        level <= din_s;
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

endmodule : sync_debounce

// File: rtl/input_conditioner.sv
// Conditions the raw ready button and switches for picomips: synchronise, debounce ready,
// capture the switch word on each debounced ready press and hold it under a valid/ack handshake.
module input_conditioner
  import picomips_pkg::*;
#(
  parameter int unsigned WIDTH           = SW_WIDTH,
  parameter int unsigned SYNC_STAGES     = DEFAULT_SYNC_STAGES,
  parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ready_raw,
  input  logic [WIDTH-1:0] sw_raw,
  output logic             ready_db,
  output logic [WIDTH-1:0] sw_hold,
  output logic             sample_valid,
  input  logic             sample_ack,
  output logic             overrun
);

  logic [WIDTH-1:0] sw_sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] sw_s;
  logic             rise;

  sync_debounce #(
    .SYNC_STAGES    (SYNC_STAGES),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_ready (
    .clk   (clk),
    .reset (reset),
    .din   (ready_raw),
    .level (ready_db),
    .rise_c(rise)
  );

  assign sw_s = sw_sync_q[SYNC_STAGES-1];

  // Switch bus synchroniser; switches are assumed settled before ready is pressed.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < int'(SYNC_STAGES); i++) sw_sync_q[i] <= '0;
    end else begin
      sw_sync_q[0] <= sw_raw;
      for (int i = 1; i < int'(SYNC_STAGES); i++) sw_sync_q[i] <= sw_sync_q[i-1];
    end
  end

  // Capture on press; a new press beats a same-edge ack, and an unacked overwrite is sticky.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sw_hold      <= '0;
      sample_valid <= 1'b0;
      overrun      <= 1'b0;
    end else if (rise) begin
      sw_hold      <= sw_s;
      sample_valid <= 1'b1;
      if (sample_valid && !sample_ack) overrun <= 1'b1;
    end else if (sample_valid && sample_ack) begin
      sample_valid <= 1'b0;
    end
  end

endmodule : input_conditioner

// File: tb/tb_input_conditioner.sv
// Directed plus randomized bench for input_conditioner against a history-based reference model.
`timescale 1ns/100ps
module tb_input_conditioner;

  localparam int unsigned W   = 8;
  localparam int unsigned S   = 2;
  localparam int unsigned D   = 4;
  localparam int unsigned LAT = S + D;

  logic         clk = 1'b0;
  logic         reset;
  logic         ready_raw;
  logic [W-1:0] sw_raw;
  logic         sample_ack;
  logic         ready_db;
  logic [W-1:0] sw_hold;
  logic         sample_valid;
  logic         overrun;

  int n_checks  = 0;
  int n_err     = 0;
  int dut_rises = 0;
  logic prev_db = 1'b0;

  // Reference model: pipelined raw samples, recent ready_s history, and handshake state.
  logic         m_rs   [S];
  logic [W-1:0] m_sw   [S];
  logic         m_hist [D];
  logic         m_db;
  logic [W-1:0] m_hold;
  logic         m_valid;
  logic         m_ovr;

  input_conditioner #(
    .WIDTH          (W),
    .SYNC_STAGES    (S),
    .DEBOUNCE_CYCLES(D)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .ready_raw   (ready_raw),
    .sw_raw      (sw_raw),
    .ready_db    (ready_db),
    .sw_hold     (sw_hold),
    .sample_valid(sample_valid),
    .sample_ack  (sample_ack),
    .overrun     (overrun)
  );

  always #1 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < int'(S); i++) begin
      m_rs[i] = 1'b0;
      m_sw[i] = '0;
    end
    for (int i = 0; i < int'(D); i++) m_hist[i] = 1'b0;
    m_db    = 1'b0;
    m_hold  = '0;
    m_valid = 1'b0;
    m_ovr   = 1'b0;
  endtask

  // One clock edge of the model, using the inputs currently applied to the DUT.
  task automatic model_step();
    logic         rs;
    logic [W-1:0] sws;
    logic         all_diff;
    logic         rise;
    if (!reset) begin
      model_reset();
      return;
    end
    rs  = m_rs[S-1];
    sws = m_sw[S-1];
    for (int i = int'(D) - 1; i > 0; i--) m_hist[i] = m_hist[i-1];
    m_hist[0] = rs;
    // Level follows only after D consecutive samples disagree with it.
    all_diff = 1'b1;
    for (int i = 0; i < int'(D); i++) if (m_hist[i] == m_db) all_diff = 1'b0;
    rise = all_diff && rs;
    if (rise) begin
      m_hold = sws;
      if (m_valid && !sample_ack) m_ovr = 1'b1;
      m_valid = 1'b1;
    end else if (m_valid && sample_ack) begin
      m_valid = 1'b0;
    end
    if (all_diff) m_db = rs;
    for (int i = int'(S) - 1; i > 0; i--) begin
      m_rs[i] = m_rs[i-1];
      m_sw[i] = m_sw[i-1];
    end
    m_rs[0] = ready_raw;
    m_sw[0] = sw_raw;
  endtask

  task automatic check_model();
    chk("ready_db", 32'(ready_db), 32'(m_db));
    chk("sw_hold", 32'(sw_hold), 32'(m_hold));
    chk("sample_valid", 32'(sample_valid), 32'(m_valid));
    chk("overrun", 32'(overrun), 32'(m_ovr));
  endtask

  // Advance one clock, starting and ending at a falling edge.
  task automatic tick();
    model_step();
    @(posedge clk);
    @(negedge clk);
    check_model();
    if (ready_db && !prev_db) dut_rises++;
    prev_db = ready_db;
  endtask

  task automatic wait_db(input logic val, output int n);
    n = 0;
    while (n < 40) begin
      tick();
      n++;
      if (ready_db == val) break;
    end
  endtask

  task automatic pulse_ack();
    sample_ack = 1'b1;
    tick();
    sample_ack = 1'b0;
  endtask

  initial begin
    int n;
    int r0;
    int remain;
    model_reset();
    reset      = 1'b0;
    ready_raw  = 1'b1;
    sw_raw     = 8'hFF;
    sample_ack = 1'b0;

    // Reset held with active inputs
    #0.5;
    chk("rst_db_t0", 32'(ready_db), 32'd0);
    chk("rst_hold_t0", 32'(sw_hold), 32'd0);
    @(negedge clk);
    repeat (3) tick();
    chk("rst_db", 32'(ready_db), 32'd0);
    chk("rst_valid", 32'(sample_valid), 32'd0);
    reset = 1'b1;
    wait_db(1'b1, n);
    chk("t1_latency", 32'(n), 32'(LAT));
    pulse_ack();
    ready_raw = 1'b0;
    wait_db(1'b0, n);
    chk("t1_fall_latency", 32'(n), 32'(LAT));

    // Capture and ack
    sw_raw = 8'h04;
    repeat (2) tick();
    ready_raw = 1'b1;
    wait_db(1'b1, n);
    chk("t2_latency", 32'(n), 32'(LAT));
    chk("t2_hold", 32'(sw_hold), 32'h04);
    chk("t2_valid", 32'(sample_valid), 32'd1);
    pulse_ack();
    chk("t2_valid_acked", 32'(sample_valid), 32'd0);
    chk("t2_hold_kept", 32'(sw_hold), 32'h04);
    ready_raw = 1'b0;
    wait_db(1'b0, n);

    // Short glitch, then a bounce
    ready_raw = 1'b1;
    repeat (3) tick();
    ready_raw = 1'b0;
    repeat (10) tick();
    chk("t3_glitch_db", 32'(ready_db), 32'd0);
    chk("t3_glitch_valid", 32'(sample_valid), 32'd0);
    chk("t3_glitch_hold", 32'(sw_hold), 32'h04);
    r0 = dut_rises;
    ready_raw = 1'b1; tick();
    ready_raw = 1'b0; tick();
    ready_raw = 1'b1;
    repeat (15) tick();
    chk("t3_bounce_rises", 32'(dut_rises - r0), 32'd1);
    pulse_ack();
    ready_raw = 1'b0;
    wait_db(1'b0, n);

    // Overrun
    sw_raw = 8'h04;
    repeat (2) tick();
    ready_raw = 1'b1;
    wait_db(1'b1, n);
    ready_raw = 1'b0;
    wait_db(1'b0, n);
    sw_raw = 8'h08;
    repeat (2) tick();
    ready_raw = 1'b1;
    wait_db(1'b1, n);
    chk("t4_hold", 32'(sw_hold), 32'h08);
    chk("t4_valid", 32'(sample_valid), 32'd1);
    chk("t4_overrun", 32'(overrun), 32'd1);
    pulse_ack();
    chk("t4_valid_acked", 32'(sample_valid), 32'd0);
    chk("t4_overrun_sticky", 32'(overrun), 32'd1);
    ready_raw = 1'b0;
    wait_db(1'b0, n);

    // Clear the sticky overrun
    reset = 1'b0;
    tick();
    chk("rst_overrun", 32'(overrun), 32'd0);
    reset   = 1'b1;
    prev_db = 1'b0;

    // Ack coinciding with a new press
    sw_raw = 8'h05;
    repeat (2) tick();
    ready_raw = 1'b1;
    wait_db(1'b1, n);
    chk("t5_hold_first", 32'(sw_hold), 32'h05);
    ready_raw = 1'b0;
    wait_db(1'b0, n);
    sw_raw = 8'h0A;
    repeat (2) tick();
    ready_raw = 1'b1;
    repeat (LAT - 1) tick();
    sample_ack = 1'b1;
    tick();
    sample_ack = 1'b0;
    chk("t5_db", 32'(ready_db), 32'd1);
    chk("t5_hold", 32'(sw_hold), 32'h0A);
    chk("t5_valid", 32'(sample_valid), 32'd1);
    chk("t5_overrun", 32'(overrun), 32'd0);

    // Asynchronous reset part-way through debouncing
    ready_raw = 1'b0;
    wait_db(1'b0, n);
    ready_raw = 1'b1;
    repeat (4) tick();
    chk("t6_pre_valid", 32'(sample_valid), 32'd1);
    #0.4;
    reset = 1'b0;
    #0.1;
    model_reset();
    chk("t6_async_hold", 32'(sw_hold), 32'd0);
    chk("t6_async_valid", 32'(sample_valid), 32'd0);
    chk("t6_async_db", 32'(ready_db), 32'd0);
    @(negedge clk);
    reset   = 1'b1;
    prev_db = 1'b0;
    wait_db(1'b1, n);
    chk("t6_latency", 32'(n), 32'(LAT));

    // Randomized traffic against the model
    remain = 0;
    repeat (600) begin
      if (remain == 0) begin
        ready_raw = 1'($urandom_range(1));
        remain    = int'($urandom_range(8, 1));
      end
      remain--;
      if ($urandom_range(3) == 0) sw_raw = W'($urandom);
      sample_ack = ($urandom_range(3) == 0);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule : tb_input_conditioner
